// File: rtl/d16_pkg.sv
// Shared constants and operation decode for the return-address stack.
package d16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 8;
    localparam int ADDR_W    = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } op_e;

    // A simultaneous push/pop on an empty stack behaves as a plain push.
    function automatic op_e decode_op(input logic push, input logic pop, input logic empty);
        op_e op;
        op = OP_NONE;
        if (push && pop) begin
            op = empty ? OP_PUSH : OP_REPL;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ret_stack.sv
// Circular return-address stack with registered top, count and sticky error flags.
module ret_stack
    import d16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         top,
    output logic                     top_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] top_q, top_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] rd_data;
    logic             empty, full;
    op_e              op;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign op    = decode_op(push, pop, empty);

    // ptr_q is the next free slot; the entry below the top sits two slots back.
    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (push_data),
        .raddr (ptr_q - AW'(2)),
        .rdata (rd_data)
    );

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        top_d   = top_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        if (clr) begin
            ptr_d   = '0;
            count_d = '0;
            top_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    wr_en   = 1'b1;
                    ptr_d   = ptr_q + AW'(1);
                    count_d = full ? count_q : count_q + CW'(1);
                    top_d   = push_data;
                    if (full) ovf_d = 1'b1;
                    if (pop)  udf_d = 1'b1;
                end
                OP_REPL: begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q - AW'(1);
                    top_d   = push_data;
                end
                OP_POP: begin
                    if (empty) begin
                        udf_d = 1'b1;
                    end else begin
                        ptr_d   = ptr_q - AW'(1);
                        count_d = count_q - CW'(1);
                        top_d   = (count_q == CW'(1)) ? '0 : rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            top_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            top_q   <= top_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign top       = top_q;
    assign top_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_ret_stack.sv
// Directed self-checking bench for ret_stack with hand-computed expectations.
module tb_ret_stack;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        push;
    logic [15:0] push_data;
    logic        pop;
    logic [15:0] top;
    logic        top_valid;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;

    ret_stack #(.WIDTH(16), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .top       (top),
        .top_valid (top_valid),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Apply one cycle of stimulus; returns 1 ns after the capturing edge.
    task automatic step(input logic p, input logic [15:0] d, input logic po, input logic c);
        push      = p;
        push_data = d;
        pop       = po;
        clr       = c;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
        @(posedge clk); #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_top", 32'(top), 0);
        chk("rst_valid", 32'(top_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
        rst_n = 1'b1;

        // Basic push/push/pop
        step(1, 16'h1234, 0, 0);
        step(1, 16'hABCD, 0, 0);
        chk("pp_top", 32'(top), 32'hABCD);
        chk("pp_count", 32'(count), 2);
        chk("pp_valid", 32'(top_valid), 1);
        step(0, 0, 1, 0);
        chk("pop_top", 32'(top), 32'h1234);
        chk("pop_count", 32'(count), 1);

        // Overflow with wrap: nine pushes into eight slots
        step(0, 0, 0, 1);
        for (int i = 1; i <= 9; i++) begin
            step(1, 16'(i), 0, 0);
            if (i == 8) begin
                chk("full_ovf", 32'(overflow), 0);
                chk("full_count", 32'(count), 8);
            end
        end
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_top", 32'(top), 9);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_top%0d", i), 32'(top), 32'(9 - i));
            step(0, 0, 1, 0);
        end
        chk("drain_count", 32'(count), 0);
        chk("drain_top", 32'(top), 0);
        chk("drain_valid", 32'(top_valid), 0);
        chk("drain_ovf_sticky", 32'(overflow), 1);

        // Underflow on empty pop, then push
        step(0, 0, 0, 1);
        chk("clr_ovf", 32'(overflow), 0);
        step(0, 0, 1, 0);
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_count", 32'(count), 0);
        chk("udf_top", 32'(top), 0);
        chk("udf_valid", 32'(top_valid), 0);
        step(1, 16'h0042, 0, 0);
        chk("udf_push_top", 32'(top), 32'h0042);
        chk("udf_sticky", 32'(underflow), 1);
        chk("udf_push_count", 32'(count), 1);

        // Simultaneous push/pop replaces the top
        step(0, 0, 0, 1);
        step(1, 16'h0011, 0, 0);
        step(1, 16'h0022, 0, 0);
        step(1, 16'h0033, 0, 0);
        step(1, 16'h7777, 1, 0);
        chk("repl_count", 32'(count), 3);
        chk("repl_top", 32'(top), 32'h7777);
        chk("repl_udf", 32'(underflow), 0);
        step(0, 0, 1, 0);
        chk("repl_pop_top", 32'(top), 32'h0022);
        chk("repl_pop_count", 32'(count), 2);

        // Simultaneous push/pop on empty acts as push and flags underflow
        step(0, 0, 0, 1);
        step(1, 16'h0BEE, 1, 0);
        chk("pp_empty_count", 32'(count), 1);
        chk("pp_empty_top", 32'(top), 32'h0BEE);
        chk("pp_empty_udf", 32'(underflow), 1);

        // Asynchronous reset mid-cycle with count=5
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 16'(16'h0100 + i), 0, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 16'(16'h0100 + i), 0, 0);
        chk("pre_arst_count", 32'(count), 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_top", 32'(top), 0);
        chk("arst_valid", 32'(top_valid), 0);
        chk("arst_ovf", 32'(overflow), 0);
        chk("arst_udf", 32'(underflow), 0);
        push = 1'b1; push_data = 16'hDEAD;
        @(posedge clk); #1;
        push = 1'b0;
        chk("arst_push_discard", 32'(count), 0);
        rst_n = 1'b1;
        step(1, 16'h0055, 0, 0);
        chk("post_arst_count", 32'(count), 1);
        chk("post_arst_top", 32'(top), 32'h0055);

        // clr with count=4 and underflow set; clr beats a simultaneous push
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 16'(16'h0200 + i), 0, 0);
        chk("pre_clr_count", 32'(count), 4);
        chk("pre_clr_udf", 32'(underflow), 1);
        step(1, 16'h0999, 0, 1);
        chk("clr_count", 32'(count), 0);
        chk("clr_top", 32'(top), 0);
        chk("clr_valid", 32'(top_valid), 0);
        chk("clr_udf", 32'(underflow), 0);
        chk("clr_ovf2", 32'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
